// File: rtl/boom_wb_multi_unit_pkg.sv
// Shared definitions for the multi-entry dcache writeback unit.
// Holds the bus/row geometry, the per-entry state encoding, the per-entry
// bookkeeping record and the TileLink C-channel opcodes used by the unit.
package wb_multi_pkg;

  // Row / block geometry and TileLink field widths
  localparam int ROW_W         = 128;
  localparam int ROW_OFF       = 4;
  localparam int TAG_W         = 20;
  localparam int IDX_W         = 6;
  localparam int N_WAYS        = 4;
  localparam int PADDR_W       = 32;
  localparam int SRC_W         = 3;
  localparam int REFILL_CYCLES = 4;
  localparam int BEAT_W        = $clog2(REFILL_CYCLES);
  localparam int CNT_W         = BEAT_W + 1;
  localparam int BLK_OFF       = ROW_OFF + BEAT_W;
  localparam int ADDR_W        = IDX_W + BLK_OFF;

  // TileLink C-channel opcodes
  localparam logic [2:0] TL_RELEASE_DATA   = 3'h7;
  localparam logic [2:0] TL_PROBE_ACK_DATA = 3'h5;

  // Lifecycle of one writeback entry
  typedef enum logic [2:0] {
    ST_INVALID = 3'd0,
    ST_QUEUED  = 3'd1,
    ST_FILL    = 3'd2,
    ST_READY   = 3'd3,
    ST_ACTIVE  = 3'd4,
    ST_GRANT   = 3'd5
  } ent_state_e;

  // Everything latched at allocation, plus the ReleaseAck flag
  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [IDX_W-1:0]  idx;
    logic [N_WAYS-1:0] way_en;
    logic [2:0]        param;
    logic              voluntary;
    logic              acked;
  } ent_rec_t;

endpackage

// File: rtl/boom_wb_multi_unit_if.sv
// Bus bundle of the writeback unit: request port, data array read port,
// C-channel release beats, D-channel ReleaseAck and the set-conflict lookup.
// Modport slave is the writeback unit; modport master is its environment
// (MSHR/prober, data array, TileLink).
interface boom_wb_multi_unit_if;
  import wb_multi_pkg::*;

  logic               req_valid;
  logic               req_ready;
  logic [TAG_W-1:0]   req_tag;
  logic [IDX_W-1:0]   req_idx;
  logic [N_WAYS-1:0]  req_way_en;
  logic [2:0]         req_param;
  logic               req_voluntary;
  logic               data_req_valid;
  logic               data_req_ready;
  logic [N_WAYS-1:0]  data_req_way_en;
  logic [ADDR_W-1:0]  data_req_addr;
  logic [ROW_W-1:0]   data_resp;
  logic               fill_done;
  logic               rel_valid;
  logic               rel_ready;
  logic [2:0]         rel_opcode;
  logic [2:0]         rel_param;
  logic [SRC_W-1:0]   rel_source;
  logic [PADDR_W-1:0] rel_address;
  logic [ROW_W-1:0]   rel_data;
  logic               grant_valid;
  logic [SRC_W-1:0]   grant_source;
  logic [IDX_W-1:0]   chk_idx;
  logic               chk_hit;

  modport slave (
    input  req_valid, req_tag, req_idx, req_way_en, req_param, req_voluntary,
    input  data_req_ready, data_resp, rel_ready, grant_valid, grant_source, chk_idx,
    output req_ready, data_req_valid, data_req_way_en, data_req_addr, fill_done,
    output rel_valid, rel_opcode, rel_param, rel_source, rel_address, rel_data, chk_hit
  );

  modport master (
    output req_valid, req_tag, req_idx, req_way_en, req_param, req_voluntary,
    output data_req_ready, data_resp, rel_ready, grant_valid, grant_source, chk_idx,
    input  req_ready, data_req_valid, data_req_way_en, data_req_addr, fill_done,
    input  rel_valid, rel_opcode, rel_param, rel_source, rel_address, rel_data, chk_hit
  );

endinterface

// File: rtl/boom_wb_multi_unit_rd_pipe.sv
// wb_rd_pipe: RD_LAT-deep delay line that tags every accepted data array read
// with its beat and entry so the response can be steered into the buffer.
// Ports: clock, reset (async, active-high); in_valid/in_beat/in_ent at the
// read handshake; out_valid/out_beat/out_ent aligned with data_resp.
module wb_rd_pipe #(
  parameter int RD_LAT = 2,
  parameter int BEAT_W = 2,
  parameter int ENT_W  = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [BEAT_W-1:0] in_beat,
  input  logic [ENT_W-1:0]  in_ent,
  output logic              out_valid,
  output logic [BEAT_W-1:0] out_beat,
  output logic [ENT_W-1:0]  out_ent
);

  logic [RD_LAT-1:0] valid_r;
  logic [BEAT_W-1:0] beat_r [RD_LAT];
  logic [ENT_W-1:0]  ent_r  [RD_LAT];

  // Shift read tags one stage per cycle; reset drops reads still in flight
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_r <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        beat_r[i] <= '0;
        ent_r[i]  <= '0;
      end
    end else begin
      valid_r[0] <= in_valid;
      beat_r[0]  <= in_beat;
      ent_r[0]   <= in_ent;
      for (int i = 1; i < RD_LAT; i++) begin
        valid_r[i] <= valid_r[i-1];
        beat_r[i]  <= beat_r[i-1];
        ent_r[i]   <= ent_r[i-1];
      end
    end
  end

  assign out_valid = valid_r[RD_LAT-1];
  assign out_beat  = beat_r[RD_LAT-1];
  assign out_ent   = ent_r[RD_LAT-1];

endmodule

// File: rtl/boom_wb_multi_unit.sv
// boom_wb_multi_unit: N_ENT-entry dcache writeback unit. Entries are allocated
// in ring order, filled one at a time from the data array, released one at a
// time on the C channel and, for voluntary releases, held until the matching
// ReleaseAck arrives on the D channel.
// Ports: clock, reset (async, active-high); bus (slave modport) carries the
// request, data array, C/D channel and set-lookup signals.
module boom_wb_multi_unit
  import wb_multi_pkg::*;
#(
  parameter int N_ENT    = 2,
  parameter int SRC_BASE = 2,
  parameter int RD_LAT   = 2
) (
  input logic                 clock,
  input logic                 reset,
  boom_wb_multi_unit_if.slave bus
);

  localparam int ENT_W = (N_ENT > 1) ? $clog2(N_ENT) : 1;

  if (SRC_BASE + N_ENT > (1 << SRC_W)) begin : g_src_range_check
    $error("boom_wb_multi_unit: source IDs SRC_BASE..SRC_BASE+N_ENT-1 do not fit in SRC_W bits");
  end

  function automatic logic [ENT_W-1:0] ptr_inc(input logic [ENT_W-1:0] p);
    if (p == ENT_W'(N_ENT - 1)) return '0;
    else return p + ENT_W'(1);
  endfunction

  function automatic logic [SRC_W-1:0] src_of(input int e);
    return SRC_W'(SRC_BASE + e);
  endfunction

  ent_state_e       state_r   [N_ENT];
  ent_state_e       state_nxt [N_ENT];
  ent_rec_t         rec_r     [N_ENT];
  logic             acked_nxt [N_ENT];
  logic [N_ENT-1:0] grant_hit;
  logic [ROW_W-1:0] row_buf   [N_ENT][REFILL_CYCLES];
  logic [ENT_W-1:0] tail_r, fill_ptr_r, rel_ptr_r;
  logic [CNT_W-1:0] issued_r, rel_beat_r;

  logic              accept, fill_busy, rd_fire, rel_fire, rel_last, chk_any;
  logic              cap_valid, cap_last;
  logic [BEAT_W-1:0] cap_beat;
  logic [ENT_W-1:0]  cap_ent;

  assign accept    = bus.req_valid && bus.req_ready;
  // Reads may start while the entry is still QUEUED so the first beat goes out
  // the cycle after allocation.
  assign fill_busy = (state_r[fill_ptr_r] == ST_QUEUED) || (state_r[fill_ptr_r] == ST_FILL);
  assign rd_fire   = bus.data_req_valid && bus.data_req_ready;
  assign rel_fire  = bus.rel_valid && bus.rel_ready;
  assign rel_last  = rel_fire && (rel_beat_r == CNT_W'(REFILL_CYCLES - 1));
  assign cap_last  = cap_valid && (cap_beat == BEAT_W'(REFILL_CYCLES - 1));

  wb_rd_pipe #(.RD_LAT(RD_LAT), .BEAT_W(BEAT_W), .ENT_W(ENT_W)) u_rd_pipe (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (rd_fire),
    .in_beat   (issued_r[BEAT_W-1:0]),
    .in_ent    (fill_ptr_r),
    .out_valid (cap_valid),
    .out_beat  (cap_beat),
    .out_ent   (cap_ent)
  );

  // ReleaseAck matching and set-conflict lookup across all entries
  always_comb begin
    chk_any = 1'b0;
    for (int e = 0; e < N_ENT; e++) begin
      grant_hit[e] = bus.grant_valid && (bus.grant_source == src_of(e)) && rec_r[e].voluntary &&
                     ((state_r[e] == ST_ACTIVE) || (state_r[e] == ST_GRANT));
      if ((state_r[e] != ST_INVALID) && (rec_r[e].idx == bus.chk_idx)) chk_any = 1'b1;
      else chk_any = chk_any;
    end
  end

  // Per-entry next state and ack flag
  always_comb begin
    for (int e = 0; e < N_ENT; e++) begin
      state_nxt[e] = state_r[e];
      acked_nxt[e] = rec_r[e].acked;
      if (accept && (tail_r == ENT_W'(e))) begin
        state_nxt[e] = ST_QUEUED;
        acked_nxt[e] = 1'b0;
      end else begin
        case (state_r[e])
          ST_QUEUED: if (fill_ptr_r == ENT_W'(e)) state_nxt[e] = ST_FILL;
                     else state_nxt[e] = ST_QUEUED;
          ST_FILL:   if (cap_last && (cap_ent == ENT_W'(e))) state_nxt[e] = ST_READY;
                     else state_nxt[e] = ST_FILL;
          ST_READY:  if (rel_ptr_r == ENT_W'(e)) state_nxt[e] = ST_ACTIVE;
                     else state_nxt[e] = ST_READY;
          ST_ACTIVE: begin
            if (grant_hit[e]) acked_nxt[e] = 1'b1;
            else acked_nxt[e] = rec_r[e].acked;
            // An ack already seen, or arriving with the last beat, skips GRANT
            if (rel_last && (rel_ptr_r == ENT_W'(e))) begin
              if (!rec_r[e].voluntary || rec_r[e].acked || grant_hit[e]) state_nxt[e] = ST_INVALID;
              else state_nxt[e] = ST_GRANT;
            end else begin
              state_nxt[e] = ST_ACTIVE;
            end
          end
          ST_GRANT:  if (grant_hit[e]) state_nxt[e] = ST_INVALID;
                     else state_nxt[e] = ST_GRANT;
          default:   state_nxt[e] = ST_INVALID;
        endcase
      end
    end
  end

  // Entry state, entry records, pointers and beat counters
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int e = 0; e < N_ENT; e++) begin
        state_r[e] <= ST_INVALID;
        rec_r[e]   <= '0;
      end
      tail_r     <= '0;
      fill_ptr_r <= '0;
      rel_ptr_r  <= '0;
      issued_r   <= '0;
      rel_beat_r <= '0;
    end else begin
      for (int e = 0; e < N_ENT; e++) begin
        state_r[e]       <= state_nxt[e];
        rec_r[e].acked   <= acked_nxt[e];
        if (accept && (tail_r == ENT_W'(e))) begin
          rec_r[e].tag       <= bus.req_tag;
          rec_r[e].idx       <= bus.req_idx;
          rec_r[e].way_en    <= bus.req_way_en;
          rec_r[e].param     <= bus.req_param;
          rec_r[e].voluntary <= bus.req_voluntary;
        end
      end
      if (accept) tail_r <= ptr_inc(tail_r);
      if (cap_last) fill_ptr_r <= ptr_inc(fill_ptr_r);
      if (rel_last) rel_ptr_r <= ptr_inc(rel_ptr_r);
      // The last capture always lands after the last read, so these never collide
      if (cap_last) issued_r <= '0;
      else if (rd_fire) issued_r <= issued_r + CNT_W'(1);
      if (rel_last) rel_beat_r <= '0;
      else if (rel_fire) rel_beat_r <= rel_beat_r + CNT_W'(1);
    end
  end

  // Beat buffer capture; contents are only observable through a valid release
  always_ff @(posedge clock) begin
    if (cap_valid) row_buf[cap_ent][cap_beat] <= bus.data_resp;
  end

  assign bus.req_ready       = (state_r[tail_r] == ST_INVALID);
  assign bus.data_req_valid  = fill_busy && (issued_r < CNT_W'(REFILL_CYCLES));
  assign bus.data_req_way_en = bus.data_req_valid ? rec_r[fill_ptr_r].way_en : '0;
  assign bus.data_req_addr   = bus.data_req_valid ?
                               {rec_r[fill_ptr_r].idx, issued_r[BEAT_W-1:0], {ROW_OFF{1'b0}}} : '0;
  assign bus.fill_done       = cap_last;
  assign bus.rel_valid       = (state_r[rel_ptr_r] == ST_ACTIVE);
  assign bus.rel_opcode      = !bus.rel_valid ? 3'h0 :
                               rec_r[rel_ptr_r].voluntary ? TL_RELEASE_DATA : TL_PROBE_ACK_DATA;
  assign bus.rel_param       = bus.rel_valid ? rec_r[rel_ptr_r].param : 3'h0;
  assign bus.rel_source      = bus.rel_valid ? src_of(int'(rel_ptr_r)) : '0;
  assign bus.rel_address     = bus.rel_valid ?
                               PADDR_W'({rec_r[rel_ptr_r].tag, rec_r[rel_ptr_r].idx, {BLK_OFF{1'b0}}}) : '0;
  assign bus.rel_data        = bus.rel_valid ? row_buf[rel_ptr_r][rel_beat_r[BEAT_W-1:0]] : '0;
  assign bus.chk_hit         = chk_any;

endmodule

// File: tb/tb_boom_wb_multi_unit.sv
// Directed self-checking bench for boom_wb_multi_unit (N_ENT=2, REFILL=4, RD_LAT=2).
// The data array is modelled as a 2-cycle read pipe returning a row derived
// from the read address, so each released beat can be predicted.
module tb_boom_wb_multi_unit;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   compared   = 0;
  int   mismatched = 0;

  boom_wb_multi_unit_if bus();

  boom_wb_multi_unit #(.N_ENT(2), .SRC_BASE(2), .RD_LAT(2)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  function automatic logic [127:0] row_of(input logic [11:0] a);
    return {a, 20'hC0FFE, a, 20'h0BEEF, a, 20'h12345, a, 20'h6789A};
  endfunction

  // Data array model: response exactly two cycles after an accepted read
  logic        rd_v1, rd_v2;
  logic [11:0] rd_a1, rd_a2;
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_v1 <= 1'b0; rd_v2 <= 1'b0; rd_a1 <= 12'h0; rd_a2 <= 12'h0;
    end else begin
      rd_v1 <= bus.data_req_valid && bus.data_req_ready;
      rd_a1 <= bus.data_req_addr;
      rd_v2 <= rd_v1;
      rd_a2 <= rd_a1;
    end
  end
  assign bus.data_resp = rd_v2 ? row_of(rd_a2) : 128'h0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.req_valid = 1'b0; bus.req_tag = 20'h0; bus.req_idx = 6'h0; bus.req_way_en = 4'h0;
    bus.req_param = 3'h0; bus.req_voluntary = 1'b0; bus.data_req_ready = 1'b1;
    bus.rel_ready = 1'b1; bus.grant_valid = 1'b0; bus.grant_source = 3'h0; bus.chk_idx = 6'h0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic send_req(input logic [19:0] tag, input logic [5:0] idx, input logic [3:0] way,
                          input logic [2:0] param, input logic vol);
    bus.req_tag = tag; bus.req_idx = idx; bus.req_way_en = way;
    bus.req_param = param; bus.req_voluntary = vol; bus.req_valid = 1'b1;
    #1;
    check("req_ready_on_accept", bus.req_ready, 1'b1);
    tick();
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_rel();
    for (int i = 0; i < 40 && bus.rel_valid !== 1'b1; i++) tick();
    check("rel_valid_timeout", bus.rel_valid, 1'b1);
  endtask

  // Check and consume n beats of one release (rel_ready must be high)
  task automatic stream_rel(input logic [2:0] op, input logic [2:0] src, input logic [31:0] addr,
                            input logic [2:0] param, input logic [11:0] dbase, input int n);
    for (int b = 0; b < n; b++) begin
      check("rel_valid", bus.rel_valid, 1'b1);
      check("rel_opcode", bus.rel_opcode, op);
      check("rel_source", bus.rel_source, src);
      check("rel_address", bus.rel_address, addr);
      check("rel_param", bus.rel_param, param);
      check("rel_data", bus.rel_data, row_of(dbase + 12'(b * 16)));
      tick();
    end
  endtask

  task automatic check_idle_outputs();
    check("idle_req_ready", bus.req_ready, 1'b1);
    check("idle_data_req_valid", bus.data_req_valid, 1'b0);
    check("idle_data_req_way_en", bus.data_req_way_en, 4'h0);
    check("idle_data_req_addr", bus.data_req_addr, 12'h0);
    check("idle_fill_done", bus.fill_done, 1'b0);
    check("idle_rel_valid", bus.rel_valid, 1'b0);
    check("idle_rel_opcode", bus.rel_opcode, 3'h0);
    check("idle_rel_param", bus.rel_param, 3'h0);
    check("idle_rel_source", bus.rel_source, 3'h0);
    check("idle_rel_address", bus.rel_address, 32'h0);
    check("idle_rel_data", bus.rel_data, 128'h0);
    check("idle_chk_hit", bus.chk_hit, 1'b0);
  endtask

  initial begin
    int nr, nb;
    do_reset();
    check_idle_outputs();

    // Probe: reads in cycles 1-4, fill_done two cycles after the last read
    bus.chk_idx = 6'h15;
    send_req(20'hABCDE, 6'h15, 4'b0010, 3'd1, 1'b0);
    for (int b = 0; b < 4; b++) begin
      check("probe_rd_valid", bus.data_req_valid, 1'b1);
      check("probe_rd_addr", bus.data_req_addr, 12'h540 + 12'(b * 16));
      check("probe_rd_way", bus.data_req_way_en, 4'b0010);
      check("probe_fill_done_early", bus.fill_done, 1'b0);
      tick();
    end
    check("probe_rd_stop", bus.data_req_valid, 1'b0);
    check("probe_chk_hit", bus.chk_hit, 1'b1);
    check("probe_ring_ready", bus.req_ready, 1'b1);
    tick();
    check("probe_fill_done", bus.fill_done, 1'b1);
    tick();
    check("probe_fill_done_pulse", bus.fill_done, 1'b0);
    wait_rel();
    stream_rel(3'h5, 3'd2, 32'hABCDE540, 3'd1, 12'h540, 4);
    check("probe_rel_end", bus.rel_valid, 1'b0);
    check("probe_freed_chk", bus.chk_hit, 1'b0);

    // Voluntary release held in GRANT until ReleaseAck for source 2
    do_reset();
    bus.chk_idx = 6'h2A;
    send_req(20'h12345, 6'h2A, 4'b0100, 3'd2, 1'b1);
    wait_rel();
    stream_rel(3'h7, 3'd2, 32'h12345A80, 3'd2, 12'hA80, 4);
    check("vol_rel_end", bus.rel_valid, 1'b0);
    repeat (10) tick();
    check("vol_grant_wait_chk", bus.chk_hit, 1'b1);
    bus.grant_valid = 1'b1; bus.grant_source = 3'd2;
    #1;
    check("vol_grant_cycle_chk", bus.chk_hit, 1'b1);
    tick();
    bus.grant_valid = 1'b0;
    #1;
    check("vol_after_grant_chk", bus.chk_hit, 1'b0);

    // Two voluntary releases, first ack withheld; third request stalls
    do_reset();
    send_req(20'h11111, 6'h01, 4'b0001, 3'd0, 1'b1);
    send_req(20'h22222, 6'h02, 4'b1000, 3'd3, 1'b1);
    wait_rel();
    stream_rel(3'h7, 3'd2, 32'h11111040, 3'd0, 12'h040, 4);
    wait_rel();
    stream_rel(3'h7, 3'd3, 32'h22222080, 3'd3, 12'h080, 4);
    bus.req_tag = 20'h33333; bus.req_idx = 6'h03; bus.req_way_en = 4'b0001;
    bus.req_param = 3'd1; bus.req_voluntary = 1'b0; bus.req_valid = 1'b1;
    #1;
    check("stall_ready0", bus.req_ready, 1'b0);
    repeat (3) tick();
    check("stall_ready1", bus.req_ready, 1'b0);
    bus.grant_valid = 1'b1; bus.grant_source = 3'd2;
    #1;
    check("stall_grant_cycle", bus.req_ready, 1'b0);
    tick();
    bus.grant_valid = 1'b0;
    #1;
    check("stall_released", bus.req_ready, 1'b1);
    tick();
    bus.req_valid = 1'b0;
    bus.chk_idx = 6'h02;
    #1;
    check("stall_second_held", bus.chk_hit, 1'b1);
    check("stall_tail_busy", bus.req_ready, 1'b0);

    // Random backpressure on both the read port and the C channel
    do_reset();
    send_req(20'h0F0F0, 6'h3F, 4'b0100, 3'd2, 1'b0);
    nr = 1; nb = 0;
    for (int c = 0; c < 300 && nb < 4; c++) begin
      bus.data_req_ready = 1'($urandom_range(0, 1));
      bus.rel_ready = 1'($urandom_range(0, 1));
      #1;
      if (bus.data_req_valid && bus.data_req_ready) begin
        check("bp_rd_addr", bus.data_req_addr, 12'hFC0 + 12'(nr * 16) - 12'h010);
        nr++;
      end
      if (bus.rel_valid && bus.rel_ready) begin
        check("bp_rel_data", bus.rel_data, row_of(12'hFC0 + 12'(nb * 16)));
        nb++;
      end
      tick();
    end
    check("bp_beats_done", 32'(nb), 32'd4);
    check("bp_reads_done", 32'(nr), 32'd5);

    // Grant in the same cycle as the last beat: straight to INVALID
    do_reset();
    bus.chk_idx = 6'h05;
    send_req(20'h55555, 6'h05, 4'b0001, 3'd0, 1'b1);
    wait_rel();
    stream_rel(3'h7, 3'd2, 32'h55555140, 3'd0, 12'h140, 3);
    bus.grant_valid = 1'b1; bus.grant_source = 3'd2;
    #1;
    check("same_cycle_last_beat", bus.rel_valid, 1'b1);
    tick();
    bus.grant_valid = 1'b0;
    #1;
    check("same_cycle_freed", bus.chk_hit, 1'b0);
    check("same_cycle_rel_off", bus.rel_valid, 1'b0);

    // Reset during beat 2 of a release; a late grant is ignored
    do_reset();
    bus.chk_idx = 6'h07;
    send_req(20'h77777, 6'h07, 4'b0010, 3'd1, 1'b1);
    wait_rel();
    stream_rel(3'h7, 3'd2, 32'h777771C0, 3'd1, 12'h1C0, 2);
    check("rst_beat2_valid", bus.rel_valid, 1'b1);
    reset = 1'b1;
    #1;
    check_idle_outputs();
    tick();
    reset = 1'b0;
    bus.grant_valid = 1'b1; bus.grant_source = 3'd2;
    tick();
    bus.grant_valid = 1'b0;
    repeat (3) tick();
    check("rst_late_grant_rel", bus.rel_valid, 1'b0);
    check("rst_late_grant_chk", bus.chk_hit, 1'b0);
    check("rst_late_grant_ready", bus.req_ready, 1'b1);
    check("rst_late_grant_rd", bus.data_req_valid, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
